// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl
// Game-flow sequencer for the brick-breaker top level. It runs the menu, the
// multi-stage play loop, the stage-clear pause and the win/lose screens. It
// also owns the lives counter, the shared skill-point pool, the per-skill
// cooldown timers and the status LEDs.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   tick              game-rate enable; every state/counter update waits for it
//   start, ball_lost  one-clk pulses, held pending until the next tick
//   bricks_empty      level, the current stage has no bricks left
//   skill_req         level per skill channel (key held)
//   state             MENU=0 PLAY=1 CLEAR=2 WIN=3 LOSE=4
//   stage             current stage index, 0-based
//   lives             remaining lives
//   skill_points      remaining skill points
//   load_stage        one-clk pulse: brick store loads `stage`
//   skill_fire        one-clk pulse per channel when a skill activates
//   skill_busy        channel cooldown is nonzero
//   led               status LEDs
module game_flow_ctrl #(
    parameter int N_STAGES     = 3,
    parameter int LIVES        = 5,
    parameter int N_SKILLS     = 3,
    parameter int SKILL_POINTS = 3,
    parameter int SKILL_CD     = 40,
    parameter int CLEAR_HOLD   = 20
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    input  logic                start,
    input  logic                ball_lost,
    input  logic                bricks_empty,
    input  logic [N_SKILLS-1:0] skill_req,
    output logic [2:0]          state,
    output logic [3:0]          stage,
    output logic [3:0]          lives,
    output logic [3:0]          skill_points,
    output logic                load_stage,
    output logic [N_SKILLS-1:0] skill_fire,
    output logic [N_SKILLS-1:0] skill_busy,
    output logic [15:0]         led
);

    typedef enum logic [2:0] {
        MENU  = 3'd0,
        PLAY  = 3'd1,
        CLEAR = 3'd2,
        WIN   = 3'd3,
        LOSE  = 3'd4
    } state_t;

    localparam logic [3:0] LAST_STAGE = 4'(N_STAGES - 1);
    localparam logic [3:0] LIVES_INIT = 4'(LIVES);
    localparam logic [3:0] PTS_MAX    = 4'(SKILL_POINTS);
    localparam logic [7:0] CD_INIT    = 8'(SKILL_CD);
    localparam logic [7:0] HOLD_END   = 8'(CLEAR_HOLD);

    state_t              state_q, state_d;
    logic [3:0]          stage_q, stage_d;
    logic [3:0]          lives_q, lives_d;
    logic [3:0]          points_q, points_d;
    logic [7:0]          hold_q, hold_d;
    logic [7:0]          cd_q [N_SKILLS];
    logic [7:0]          cd_d [N_SKILLS];
    logic                start_pend_q, start_pend_d;
    logic                lost_pend_q, lost_pend_d;
    logic [N_SKILLS-1:0] req_prev_q, req_prev_d;
    logic                load_stage_q, load_stage_d;
    logic [N_SKILLS-1:0] skill_fire_q, skill_fire_d;

    // State register
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; the comb blocks below use blocking.
    // NOTE: the cooldown array is a handful of flops, not a RAM, so it is
    // reset together with the rest of the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= MENU;
            stage_q      <= '0;
            lives_q      <= '0;
            points_q     <= '0;
            hold_q       <= '0;
            cd_q         <= '{default: '0};
            start_pend_q <= 1'b0;
            lost_pend_q  <= 1'b0;
            req_prev_q   <= '0;
            load_stage_q <= 1'b0;
            skill_fire_q <= '0;
        end else begin
            state_q      <= state_d;
            stage_q      <= stage_d;
            lives_q      <= lives_d;
            points_q     <= points_d;
            hold_q       <= hold_d;
            cd_q         <= cd_d;
            start_pend_q <= start_pend_d;
            lost_pend_q  <= lost_pend_d;
            req_prev_q   <= req_prev_d;
            load_stage_q <= load_stage_d;
            skill_fire_q <= skill_fire_d;
        end
    end

    // Next-state logic
    logic       start_now, lost_now, fired;
    logic [7:0] hold_inc;

    // NOTE: every variable gets a default at the top so no path infers a latch.
    always_comb begin
        state_d      = state_q;
        stage_d      = stage_q;
        lives_d      = lives_q;
        points_d     = points_q;
        hold_d       = hold_q;
        cd_d         = cd_q;
        req_prev_d   = req_prev_q;
        load_stage_d = 1'b0;
        skill_fire_d = '0;
        fired        = 1'b0;
        hold_inc     = hold_q + 8'd1;

        // A pulse landing in the same cycle as tick is consumed by that tick.
        start_now    = start_pend_q | start;
        lost_now     = lost_pend_q | ball_lost;
        start_pend_d = start_now;
        lost_pend_d  = lost_now;

        if (tick) begin
            start_pend_d = 1'b0;
            lost_pend_d  = 1'b0;
            req_prev_d   = skill_req;

            if (state_q == PLAY || state_q == CLEAR) begin
                for (int i = 0; i < N_SKILLS; i++) begin
                    if (cd_q[i] != 8'd0) cd_d[i] = cd_q[i] - 8'd1;
                end
            end

            case (state_q)
                MENU: begin
                    if (start_now) begin
                        state_d      = PLAY;
                        stage_d      = '0;
                        lives_d      = LIVES_INIT;
                        points_d     = PTS_MAX;
                        cd_d         = '{default: '0};
                        load_stage_d = 1'b1;
                    end
                end
                PLAY: begin
                    // Lowest eligible rising edge wins; the rest are dropped.
                    if (points_q != 4'd0) begin
                        for (int i = 0; i < N_SKILLS; i++) begin
                            if (!fired && skill_req[i] && !req_prev_q[i] && cd_q[i] == 8'd0) begin
                                fired           = 1'b1;
                                skill_fire_d[i] = 1'b1;
                                cd_d[i]         = CD_INIT;
                                points_d        = points_q - 4'd1;
                            end
                        end
                    end
                    // Clearing the stage takes priority over a lost ball.
                    if (bricks_empty) begin
                        if (stage_q == LAST_STAGE) begin
                            state_d = WIN;
                        end else begin
                            state_d = CLEAR;
                            hold_d  = '0;
                        end
                    end else if (lost_now) begin
                        lives_d = (lives_q != 4'd0) ? lives_q - 4'd1 : 4'd0;
                        if (lives_q <= 4'd1) state_d = LOSE;
                    end
                end
                CLEAR: begin
                    hold_d = hold_inc;
                    if (hold_inc == HOLD_END) begin
                        state_d      = PLAY;
                        load_stage_d = 1'b1;
                        if (stage_q != LAST_STAGE) stage_d = stage_q + 4'd1;
                        if (points_q < PTS_MAX) points_d = points_q + 4'd1;
                    end
                end
                WIN, LOSE: begin
                    if (start_now) state_d = MENU;
                end
                default: state_d = MENU;
            endcase

            if (state_d != state_q && (state_d == MENU || state_d == WIN || state_d == LOSE))
                cd_d = '{default: '0};
        end
    end

    // Output logic
    always_comb begin
        state        = state_q;
        stage        = stage_q;
        lives        = lives_q;
        skill_points = points_q;
        load_stage   = load_stage_q;
        skill_fire   = skill_fire_q;
        for (int i = 0; i < N_SKILLS; i++) skill_busy[i] = (cd_q[i] != 8'd0);

        led = 16'h0000;
        case (state_q)
            PLAY, CLEAR: begin
                // Lives fill upward from bit 0, points fill downward from bit 15.
                for (int i = 0; i < 8; i++) begin
                    led[i]      = (4'(i) < lives_q);
                    led[15 - i] = (4'(i) < points_q);
                end
            end
            WIN:     led = 16'hFFFF;
            LOSE:    led = 16'hAAAA;
            default: led = 16'h0000;
        endcase
    end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Self-checking bench for game_flow_ctrl with default parameters.
module tb_game_flow_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick = 1'b0, start = 1'b0, ball_lost = 1'b0, bricks_empty = 1'b0;
    logic [2:0]  skill_req = '0;
    logic [2:0]  state;
    logic [3:0]  stage, lives, skill_points;
    logic        load_stage;
    logic [2:0]  skill_fire, skill_busy;
    logic [15:0] led;

    int n_checks = 0;
    int n_errors = 0;

    game_flow_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .tick         (tick),
        .start        (start),
        .ball_lost    (ball_lost),
        .bricks_empty (bricks_empty),
        .skill_req    (skill_req),
        .state        (state),
        .stage        (stage),
        .lives        (lives),
        .skill_points (skill_points),
        .load_stage   (load_stage),
        .skill_fire   (skill_fire),
        .skill_busy   (skill_busy),
        .led          (led)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        t, s, l, e;
        logic [2:0]  r;
        logic [2:0]  st;
        logic [3:0]  stg, lv, pt;
        logic        ld;
        logic [2:0]  fr, bs;
        logic [15:0] led;
    } vec_t;

    vec_t vec [15];

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s[%0d] got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int idx,
                             input logic [2:0] st, input logic [3:0] stg, input logic [3:0] lv,
                             input logic [3:0] pt, input logic ld, input logic [2:0] fr,
                             input logic [2:0] bs, input logic [15:0] ld_led);
        check({tag, ".state"},        idx, 32'(state),        32'(st));
        check({tag, ".stage"},        idx, 32'(stage),        32'(stg));
        check({tag, ".lives"},        idx, 32'(lives),        32'(lv));
        check({tag, ".skill_points"}, idx, 32'(skill_points), 32'(pt));
        check({tag, ".load_stage"},   idx, 32'(load_stage),   32'(ld));
        check({tag, ".skill_fire"},   idx, 32'(skill_fire),   32'(fr));
        check({tag, ".skill_busy"},   idx, 32'(skill_busy),   32'(bs));
        check({tag, ".led"},          idx, 32'(led),          32'(ld_led));
    endtask

    // One clk cycle: drive after the falling edge, sample 1 ns after the rising edge.
    task automatic step(input logic t, input logic s, input logic l, input logic e, input logic [2:0] r);
        @(negedge clk);
        tick = t; start = s; ball_lost = l; bricks_empty = e; skill_req = r;
        @(posedge clk);
        #1;
        tick = 1'b0; start = 1'b0; ball_lost = 1'b0;
    endtask

    initial begin
        //            t  s  l  e  req     st  stg lv pt ld fire    busy    led
        vec[0]  = '{1, 0, 0, 0, 3'b000, 0,  0,  0, 0, 0, 3'b000, 3'b000, 16'h0000};
        vec[1]  = '{0, 1, 0, 0, 3'b000, 0,  0,  0, 0, 0, 3'b000, 3'b000, 16'h0000};
        vec[2]  = '{1, 0, 0, 0, 3'b000, 1,  0,  5, 3, 1, 3'b000, 3'b000, 16'hE01F};
        vec[3]  = '{0, 0, 0, 0, 3'b000, 1,  0,  5, 3, 0, 3'b000, 3'b000, 16'hE01F};
        vec[4]  = '{0, 0, 1, 0, 3'b000, 1,  0,  5, 3, 0, 3'b000, 3'b000, 16'hE01F};
        vec[5]  = '{0, 0, 1, 0, 3'b000, 1,  0,  5, 3, 0, 3'b000, 3'b000, 16'hE01F};
        vec[6]  = '{1, 0, 0, 0, 3'b000, 1,  0,  4, 3, 0, 3'b000, 3'b000, 16'hE00F};
        vec[7]  = '{1, 0, 1, 0, 3'b000, 1,  0,  3, 3, 0, 3'b000, 3'b000, 16'hE007};
        vec[8]  = '{1, 0, 0, 0, 3'b111, 1,  0,  3, 2, 0, 3'b001, 3'b001, 16'hC007};
        vec[9]  = '{0, 0, 0, 0, 3'b111, 1,  0,  3, 2, 0, 3'b000, 3'b001, 16'hC007};
        vec[10] = '{1, 0, 0, 0, 3'b000, 1,  0,  3, 2, 0, 3'b000, 3'b001, 16'hC007};
        vec[11] = '{1, 0, 0, 0, 3'b010, 1,  0,  3, 1, 0, 3'b010, 3'b011, 16'h8007};
        vec[12] = '{1, 0, 0, 0, 3'b011, 1,  0,  3, 1, 0, 3'b000, 3'b011, 16'h8007};
        vec[13] = '{0, 0, 1, 0, 3'b000, 1,  0,  3, 1, 0, 3'b000, 3'b011, 16'h8007};
        vec[14] = '{1, 0, 0, 1, 3'b000, 2,  0,  3, 1, 0, 3'b000, 3'b011, 16'h8007};

        // Reset state while rst is held.
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 0, 3'd0, 4'd0, 4'd0, 4'd0, 1'b0, 3'b000, 3'b000, 16'h0000);
        @(negedge clk);
        rst = 1'b0;

        // Start, lives, skills, then a clear with a pending ball_lost.
        for (int i = 0; i < 15; i++) begin
            step(vec[i].t, vec[i].s, vec[i].l, vec[i].e, vec[i].r);
            check_all("vec", i, vec[i].st, vec[i].stg, vec[i].lv, vec[i].pt,
                      vec[i].ld, vec[i].fr, vec[i].bs, vec[i].led);
        end

        // Stage-clear pause: 19 ticks hold, the 20th loads stage 1.
        for (int i = 1; i < 20; i++) begin
            step(1, 0, 0, 0, 3'b000);
            check("clear_hold.state", i, 32'(state), 32'd2);
        end
        step(1, 0, 0, 0, 3'b000);
        check_all("clear_exit", 0, 3'd1, 4'd1, 4'd3, 4'd2, 1'b1, 3'b000, 3'b011, 16'hC007);
        step(0, 0, 0, 0, 3'b000);
        check("clear_exit.load_drop", 0, 32'(load_stage), 32'd0);

        // Channel 0 fired 24 ticks ago: busy through 39 ticks, clear on the 40th.
        for (int i = 0; i < 15; i++) step(1, 0, 0, 0, 3'b000);
        check("cooldown.busy39", 0, 32'(skill_busy), 32'b011);
        step(1, 0, 0, 0, 3'b000);
        check("cooldown.busy40", 0, 32'(skill_busy), 32'b010);

        // Clear stage 1, then the last stage wins.
        step(1, 0, 0, 1, 3'b000);
        check("clear1.state", 0, 32'(state), 32'd2);
        for (int i = 0; i < 20; i++) step(1, 0, 0, 0, 3'b000);
        check_all("stage2", 0, 3'd1, 4'd2, 4'd3, 4'd3, 1'b1, 3'b000, 3'b000, 16'hE007);
        step(1, 0, 0, 1, 3'b000);
        check_all("win", 0, 3'd3, 4'd2, 4'd3, 4'd3, 1'b0, 3'b000, 3'b000, 16'hFFFF);
        step(1, 1, 0, 0, 3'b000);
        check("win_to_menu.state", 0, 32'(state), 32'd0);
        check("win_to_menu.led", 0, 32'(led), 32'h0000);

        // Fresh game, five lost balls.
        step(1, 1, 0, 0, 3'b000);
        check_all("restart", 0, 3'd1, 4'd0, 4'd5, 4'd3, 1'b1, 3'b000, 3'b000, 16'hE01F);
        for (int i = 1; i <= 5; i++) begin
            step(0, 0, 1, 0, 3'b000);
            step(1, 0, 0, 0, 3'b000);
            check("lose.lives", i, 32'(lives), 32'(5 - i));
            check("lose.state", i, 32'(state), (i == 5) ? 32'd4 : 32'd1);
        end
        check("lose.led", 0, 32'(led), 32'hAAAA);

        // Back to play; a clear with a full pool keeps points saturated.
        step(1, 1, 0, 0, 3'b000);
        check("lose_to_menu.state", 0, 32'(state), 32'd0);
        step(1, 1, 0, 0, 3'b000);
        step(1, 0, 0, 1, 3'b000);
        for (int i = 0; i < 20; i++) step(1, 0, 0, 0, 3'b000);
        check_all("sat", 0, 3'd1, 4'd1, 4'd5, 4'd3, 1'b1, 3'b000, 3'b000, 16'hE01F);

        // Asynchronous reset mid-CLEAR, between ticks, with no clock edge.
        step(1, 0, 0, 1, 3'b000);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 3'b000);
        check("pre_rst.state", 0, 32'(state), 32'd2);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_all("async_rst", 0, 3'd0, 4'd0, 4'd0, 4'd0, 1'b0, 3'b000, 3'b000, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        step(1, 0, 0, 0, 3'b000);
        check("post_rst.state", 0, 32'(state), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/game_flow_ctrl.md
# game_flow_ctrl

Parametrised game-flow controller for the brick-breaker top level. It sequences menu, multi-stage play, stage-clear pause, win and lose. It also owns the lives counter, the shared skill-point pool and per-skill cooldown timers, and drives the status LEDs. Ball/brick physics and rendering consume its `state`, `stage`, `load_stage` and `skill_fire` outputs.

## Interface
- `N_STAGES`, default 3: number of stages, range 1..16.
- `LIVES`, default 5: lives at game start, range 1..8.
- `N_SKILLS`, default 3: skill channels, range 1..8.
- `SKILL_POINTS`, default 3: skill-point pool size, range 1..8.
- `SKILL_CD`, default 40: cooldown length in ticks, range 1..255.
- `CLEAR_HOLD`, default 20: stage-clear pause length in ticks, range 1..255.

Ports (name, direction, width, meaning):
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset.
- `tick` in 1: game-rate enable, one `clk` wide.
- `start` in 1: start request, one-`clk` pulse.
- `ball_lost` in 1: ball fell below the paddle, one-`clk` pulse.
- `bricks_empty` in 1: level, current stage has no bricks left.
- `skill_req` in N_SKILLS: level, key held per skill.
- `state` out 3: MENU=0, PLAY=1, CLEAR=2, WIN=3, LOSE=4.
- `stage` out 4: current stage index, 0-based.
- `lives` out 4: remaining lives.
- `skill_points` out 4: remaining points.
- `load_stage` out 1: one-`clk` pulse telling the brick store to load `stage`.
- `skill_fire` out N_SKILLS: one-`clk` pulse when a skill activates.
- `skill_busy` out N_SKILLS: the channel's cooldown is nonzero.
- `led` out 16: status LEDs.

## Operation
- **Input capture.** `start` and `ball_lost` pulses set sticky pending flags on any `clk`. The flags are consumed and cleared at the next `tick` edge. A pulse arriving in the same cycle as `tick` is consumed by that tick.
- **Update rule.** All FSM, counter and cooldown updates happen only on `clk` edges where `tick`=1.
- **MENU.** Start pending → go to PLAY. Set `stage`=0, `lives`=LIVES, `skill_points`=SKILL_POINTS, clear all cooldowns, pulse `load_stage`.
- **PLAY, `bricks_empty`=1.** If `stage`==N_STAGES-1 → WIN, otherwise → CLEAR with the hold counter set to 0. In this case a pending `ball_lost` is discarded and no life is lost.
- **PLAY, otherwise, ball_lost pending.** `lives`−1. If the result is 0 → LOSE.
- **CLEAR.** The hold counter increments each tick. On the tick where it reaches CLEAR_HOLD:
  - `stage`+1, pulse `load_stage`, → PLAY;
  - `skill_points`+1, saturating at SKILL_POINTS.
- **WIN / LOSE.** Start pending → MENU. All counters hold their values until then.
- **Skills (PLAY only).**
  - `skill_req` is sampled each tick; a rising edge is a 0→1 change versus the previous tick's sample.
  - An edge on channel i is eligible when `skill_points`>0 and cooldown[i]==0.
  - Only the lowest eligible index fires per tick. Other edges in that tick are dropped.
  - On fire: `skill_points`−1, cooldown[i]=SKILL_CD, `skill_fire[i]`=1.
- **Cooldowns.** Each nonzero cooldown decrements by 1 per tick in PLAY and CLEAR. All cooldowns are forced to 0 on entry to MENU, WIN or LOSE.
- **LED.**
  - MENU: 16'h0000.
  - PLAY or CLEAR: `led[7:0]` is a thermometer of `lives` (bit 0 upward). `led[15:8]` is a thermometer of `skill_points` filled from bit 15 downward.
  - WIN: 16'hFFFF.
  - LOSE: 16'hAAAA.
- **Widths.**
  - `lives` never wraps below 0.
  - `stage` never exceeds N_STAGES-1.
  - Cooldown counters are 8 bits; the hold counter is 8 bits.

## Timing
- Reset values: `state`=MENU, `stage`=0, `lives`=0, `skill_points`=0, all cooldowns 0, pending flags 0, `load_stage`=0, `skill_fire`=0, `led`=16'h0000.
- Reset is asynchronous and takes effect mid-operation, from any state, without waiting for `tick`.
- Registered outputs change on the `tick` edge.
- `load_stage` and `skill_fire` are high for exactly one `clk`: the cycle after the `tick` edge that caused them. They clear on the next `clk` edge regardless of `tick`.
- Decision latency from input to outputs: pulse-type inputs (`start`, `ball_lost`) act on the first `tick` edge at or after the pulse. Level inputs (`bricks_empty`, `skill_req`) are sampled only on `tick` edges.
- Back-to-back `ball_lost` pulses between two ticks cost one life total.

## Test plan
- Start pulse, then a tick → `state`=1, `stage`=0, `lives`=5, `skill_points`=3, `load_stage` high 1 clk, `led`=16'hE01F.
- Five `ball_lost` pulses, each followed by a tick → `lives` 4,3,2,1,0; `state`=4 after the fifth; `led`=16'hAAAA.
- `bricks_empty` and `ball_lost` pending on the same tick, stage 0 → `state`=2, `lives` unchanged. After 20 ticks: `stage`=1, `state`=1, `load_stage` pulse.
- `skill_req`=3'b111 rising on one tick → only `skill_fire[0]` pulses, `skill_points`=2. A re-press of channel 0 within 40 ticks is ignored (`skill_busy[0]`=1). On the 40th tick after fire, `skill_busy[0]` drops.
- Clear the final stage (stage 2) → `state`=3, `led`=16'hFFFF. A start pulse → MENU.
- Assert `rst` mid-CLEAR, between ticks → all outputs reach reset values immediately.
